// File: rtl/qkt_score_unit.sv
// rtl/qkt_score_unit.sv - attention score stage computing S = Q x K^T over the shared result SRAM
// One Q row is held in a local buffer while every K row streams through the single read port.
module qkt_score_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int MAX_D  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              ready,
  output logic              err,
  input  logic [ADDR_W-1:0] q_base,
  input  logic [ADDR_W-1:0] k_base,
  input  logic [ADDR_W-1:0] s_base,
  input  logic [15:0]       num_rows,
  input  logic [15:0]       num_cols,
  output logic [ADDR_W-1:0] sram_read_address,
  input  logic [DATA_W-1:0] sram_read_data,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic [DATA_W-1:0] sram_write_data
);
  localparam int CNT_W = $clog2(MAX_D + 1);
  localparam int IDX_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SKIP, S_LOAD_Q, S_MAC_K, S_WRITE_S, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_k_base, r_q_ptr, r_k_ptr, r_s_ptr;
  logic [15:0]       r_n, r_i, r_j;
  logic [CNT_W-1:0]  r_d, r_k;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_acc;
  logic              r_err;
  logic [DATA_W-1:0] r_qbuf [0:MAX_D-1];

  logic              w_accept, w_degen, w_too_wide, w_last_k, w_last_j, w_last_i;
  logic [DATA_W-1:0] w_prod;

  assign w_accept   = start && (r_state == S_IDLE);
  assign w_degen    = (num_rows == 16'd0) || (num_cols == 16'd0);
  assign w_too_wide = num_cols > 16'(MAX_D);
  assign w_last_k   = (r_k == r_d);
  assign w_last_j   = (r_j == r_n - 16'd1);
  assign w_last_i   = (r_i == r_n - 16'd1);
  assign w_prod     = r_qbuf[r_idx] * sram_read_data;

  assign ready              = (r_state == S_IDLE);
  assign err                = r_err;
  assign sram_read_address  = (r_state == S_MAC_K) ? r_k_ptr : r_q_ptr;
  assign sram_write_enable  = (r_state == S_WRITE_S);
  assign sram_write_address = r_s_ptr;
  assign sram_write_data    = r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Rejected jobs pass through S_SKIP so they still spend two cycles busy.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = (w_degen || w_too_wide) ? S_SKIP : S_LOAD_Q;
      S_SKIP:    w_next = S_DONE;
      S_LOAD_Q:  if (w_last_k) w_next = S_MAC_K;
      S_MAC_K:   if (w_last_k) w_next = S_WRITE_S;
      S_WRITE_S: begin
        if (!w_last_j)      w_next = S_MAC_K;
        else if (!w_last_i) w_next = S_LOAD_Q;
        else                w_next = S_DONE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k_base <= '0;
      r_q_ptr  <= '0;
      r_k_ptr  <= '0;
      r_s_ptr  <= '0;
      r_n      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_d      <= '0;
      r_k      <= '0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_err    <= !w_degen && w_too_wide;
          r_n      <= num_rows;
          r_d      <= num_cols[CNT_W-1:0];
          r_k_base <= k_base;
          r_i      <= '0;
          r_j      <= '0;
          r_k      <= '0;
          r_idx    <= '0;
          if (!w_degen && !w_too_wide) begin
            r_q_ptr <= q_base;
            r_k_ptr <= k_base;
            r_s_ptr <= s_base;
          end
        end
        S_LOAD_Q: begin
          if (!w_last_k) r_q_ptr <= r_q_ptr + 1'b1;
          if (r_k != '0) r_idx <= r_idx + 1'b1;
          r_k <= w_last_k ? '0 : r_k + 1'b1;
          if (w_last_k) begin
            r_idx <= '0;
            r_acc <= '0;
          end
        end
        S_MAC_K: begin
          // Read data lags its address by one cycle, so cycle k accumulates element k-1.
          if (!w_last_k) r_k_ptr <= r_k_ptr + 1'b1;
          if (r_k != '0) begin
            r_acc <= r_acc + w_prod;
            r_idx <= r_idx + 1'b1;
          end
          r_k <= w_last_k ? '0 : r_k + 1'b1;
          if (w_last_k) r_idx <= '0;
        end
        S_WRITE_S: begin
          r_s_ptr <= r_s_ptr + 1'b1;
          if (!w_last_j) begin
            r_j   <= r_j + 16'd1;
            r_acc <= '0;
          end else if (!w_last_i) begin
            r_i     <= r_i + 16'd1;
            r_j     <= '0;
            r_k_ptr <= r_k_base;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_Q && r_k != '0) r_qbuf[r_idx] <= sram_read_data;
  end

endmodule

// File: tb/tb_qkt_score_unit.sv
// tb/tb_qkt_score_unit.sv - scoreboard bench for qkt_score_unit with an SRAM model
// Expected S writes are queued at stimulus time and popped by an independent write monitor.
module tb_qkt_score_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        ready, err;
  logic [15:0] q_base = '0, k_base = '0, s_base = '0;
  logic [15:0] num_rows = '0, num_cols = '0;
  logic [15:0] sram_read_address, sram_write_address;
  logic [31:0] sram_read_data;
  logic        sram_write_enable;
  logic [31:0] sram_write_data;

  qkt_score_unit #(.ADDR_W(16), .DATA_W(32), .MAX_D(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ready(ready), .err(err),
    .q_base(q_base), .k_base(k_base), .s_base(s_base),
    .num_rows(num_rows), .num_cols(num_cols),
    .sram_read_address(sram_read_address), .sram_read_data(sram_read_data),
    .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
    .sram_write_data(sram_write_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    sram_read_data <= mem[sram_read_address];
    if (sram_write_enable) mem[sram_write_address] = sram_write_data;
  end

  int          errors = 0;
  int          checks = 0;
  logic [47:0] exp_q[$];
  int          qv[256];
  int          kv[256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [47:0] e;
    if (sram_write_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual=%h:%h required=none", sram_write_address, sram_write_data);
      end else begin
        e = exp_q.pop_front();
        if ({sram_write_address, sram_write_data} !== e) begin
          errors++;
          $display("FAIL wr actual=%h:%h required=%h:%h",
                   sram_write_address, sram_write_data, e[47:32], e[31:0]);
        end
      end
    end
  end

  task automatic load_mem(input int n, input int d, input logic [15:0] qb, input logic [15:0] kb);
    for (int x = 0; x < n * d; x++) begin
      mem[qb + 16'(x)] = qv[x];
      mem[kb + 16'(x)] = kv[x];
    end
  endtask

  // S[i][j] = sum_k Q[i][k]*K[j][k] in 32-bit wrapping signed arithmetic, written row-major.
  task automatic push_model(input int n, input int d, input logic [15:0] sb);
    int acc;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < d; k++) acc += qv[i*d + k] * kv[j*d + k];
        exp_q.push_back({sb + 16'(i*n + j), 32'(acc)});
      end
  endtask

  task automatic run_job(input int n, input int d, input logic [15:0] qb, input logic [15:0] kb,
                         input logic [15:0] sb, input bit noise, input bit exp_err);
    int          c, lat_exp;
    bit          quiet, ra_moved;
    logic [15:0] ra0;
    quiet   = (n == 0) || (d == 0) || (d > 64);
    lat_exp = quiet ? 2 : n * ((d + 1) + n * (d + 2)) + 1;
    @(posedge clk); #1;
    q_base = qb; k_base = kb; s_base = sb;
    num_rows = 16'(n); num_cols = 16'(d);
    start = 1'b1;
    ra0 = sram_read_address;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    ra_moved = 1'b0;
    chk("ready_drop", 64'(ready), 64'd0);
    while (!ready && c < 5000) begin
      if (noise && c < 10) begin
        start = c[0];
        q_base = 16'($urandom); k_base = 16'($urandom); s_base = 16'($urandom);
        num_rows = 16'($urandom_range(1, 4)); num_cols = 16'($urandom_range(1, 8));
      end else start = 1'b0;
      @(posedge clk); #1;
      c++;
      if (sram_read_address !== ra0) ra_moved = 1'b1;
    end
    start = 1'b0;
    chk("latency", 64'(c), 64'(lat_exp));
    chk("err", 64'(err), 64'(exp_err));
    chk("drain", 64'(exp_q.size()), 64'd0);
    if (quiet) chk("no_reads", 64'(ra_moved), 64'd0);
    exp_q.delete();
  endtask

  task automatic rand_data(input int cnt);
    for (int x = 0; x < cnt; x++) begin
      qv[x] = int'($urandom);
      kv[x] = int'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, d;
    logic [15:0] qb, kb, sb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_we", 64'(sram_write_enable), 64'd0);
    chk("rst_raddr", 64'(sram_read_address), 64'd0);
    chk("rst_waddr", 64'(sram_write_address), 64'd0);
    chk("rst_wdata", 64'(sram_write_data), 64'd0);
    reset_n = 1'b1;

    qv[0] = 1; qv[1] = 2; qv[2] = 3; qv[3] = 4;
    kv[0] = 5; kv[1] = 6; kv[2] = 7; kv[3] = 8;
    load_mem(2, 2, 16'h0010, 16'h0020);
    exp_q.push_back({16'h0030, 32'd17});
    exp_q.push_back({16'h0031, 32'd23});
    exp_q.push_back({16'h0032, 32'd39});
    exp_q.push_back({16'h0033, 32'd53});
    run_job(2, 2, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0);

    qv[0] = 32'h0001_0000; kv[0] = 32'h0001_0000;
    load_mem(1, 1, 16'h0040, 16'h0050);
    exp_q.push_back({16'h0060, 32'h0000_0000});
    run_job(1, 1, 16'h0040, 16'h0050, 16'h0060, 1'b0, 1'b0);

    qv[0] = -3; kv[0] = 7;
    load_mem(1, 1, 16'h0040, 16'h0050);
    exp_q.push_back({16'h0061, 32'hFFFF_FFEB});
    run_job(1, 1, 16'h0040, 16'h0050, 16'h0061, 1'b0, 1'b0);

    run_job(3, 0, 16'h0070, 16'h0080, 16'h0090, 1'b0, 1'b0);
    run_job(2, 65, 16'h0070, 16'h0080, 16'h0090, 1'b0, 1'b1);
    rand_data(6);
    load_mem(2, 3, 16'h0100, 16'h0110);
    push_model(2, 3, 16'h0120);
    run_job(2, 3, 16'h0100, 16'h0110, 16'h0120, 1'b0, 1'b0);

    // Abandon a 2x2 job during the second MAC_K pass: exactly one of its four writes may appear.
    rand_data(4);
    load_mem(2, 2, 16'h0200, 16'h0210);
    push_model(2, 2, 16'h0220);
    @(posedge clk); #1;
    q_base = 16'h0200; k_base = 16'h0210; s_base = 16'h0220;
    num_rows = 16'd2; num_cols = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ready), 64'd1);
    chk("arst_we", 64'(sram_write_enable), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("arst_writes_left", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    rand_data(4);
    load_mem(2, 2, 16'h0200, 16'h0210);
    push_model(2, 2, 16'h0230);
    run_job(2, 2, 16'h0200, 16'h0210, 16'h0230, 1'b0, 1'b0);

    rand_data(4);
    load_mem(2, 2, 16'h0300, 16'h0310);
    push_model(2, 2, 16'h0320);
    run_job(2, 2, 16'h0300, 16'h0310, 16'h0320, 1'b1, 1'b0);

    for (int t = 0; t < 5; t++) begin
      n  = int'($urandom_range(1, 4));
      d  = int'($urandom_range(1, 8));
      qb = 16'h1000 + 16'($urandom_range(0, 255));
      kb = 16'h2000 + 16'($urandom_range(0, 255));
      sb = 16'h3000 + 16'($urandom_range(0, 255));
      rand_data(n * d);
      load_mem(n, d, qb, kb);
      push_model(n, d, sb);
      run_job(n, d, qb, kb, sb, 1'b0, 1'b0);
    end

    rand_data(256);
    load_mem(4, 64, 16'h1000, 16'h2000);
    push_model(4, 64, 16'hFFFE);
    run_job(4, 64, 16'h1000, 16'h2000, 16'hFFFE, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qkt_score_unit.md
Name: qkt_score_unit

Overview:
- Downstream stage of the Q/K/V projection engine in the self-attention datapath.
- Once the projection engine has written Q and K row-major into the result SRAM, this block computes S = Q x K^T.
- It writes S row-major back into the same result SRAM.
- It has one read port and one write port, so each Q row is buffered locally while the K rows are streamed past it.

Parameters:
- ADDR_W, 16, SRAM address width.
- DATA_W, 32, SRAM word width; all arithmetic uses this width.
- MAX_D, 64, maximum supported num_cols, which is also the depth of the local Q-row buffer.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to begin; sampled only while ready=1.
- ready  out  1  high when idle and able to accept start.
- err  out  1  sticky; set when an accepted job has num_cols>MAX_D; cleared on the next accepted start.
- q_base  in  ADDR_W  word address of Q[0][0]; latched on start.
- k_base  in  ADDR_W  word address of K[0][0]; latched on start.
- s_base  in  ADDR_W  word address of S[0][0]; latched on start.
- num_rows  in  16  N, the token count (rows of Q and K); latched on start.
- num_cols  in  16  D, the head dimension; latched on start.
- sram_read_address  out  ADDR_W  result SRAM read address.
- sram_read_data  in  DATA_W  result SRAM read data, valid one cycle after its address is presented.
- sram_write_enable  out  1  result SRAM write strobe.
- sram_write_address  out  ADDR_W  result SRAM write address.
- sram_write_data  out  DATA_W  result SRAM write data.

Behaviour:
- Reset values (also applied on any mid-operation reset, which abandons the job):
  - state=IDLE, ready=1, err=0.
  - sram_write_enable=0, sram_read_address=0, sram_write_address=0, sram_write_data=0.
  - Q buffer contents are don't-care.
- Accepting a job:
  - start && ready at edge E0 latches all inputs, clears err, and drops ready at E0.
  - start while ready=0 is ignored.
- State IDLE:
  - On an accepted start, if N==0 or D==0, go to DONE with no writes.
  - Else if D>MAX_D, set err and go to DONE with no SRAM accesses.
  - Else go to LOAD_Q with i=0.
- State LOAD_Q (D+1 cycles):
  - Cycles 0..D-1 present q_base+i*D+k for k=0..D-1.
  - Cycles 1..D store sram_read_data into qbuf[k-1].
  - Then go to MAC_K with j=0 and acc=0.
- State MAC_K (D+1 cycles):
  - Cycles 0..D-1 present k_base+j*D+k.
  - Cycles 1..D compute acc = acc + qbuf[k-1]*sram_read_data.
  - Then go to WRITE_S.
- State WRITE_S (1 cycle):
  - Drive sram_write_enable=1, sram_write_address=s_base+i*N+j, sram_write_data=acc.
  - If j<N-1: j++, acc=0, go to MAC_K.
  - Else if i<N-1: i++, go to LOAD_Q.
  - Else go to DONE.
- State DONE (1 cycle):
  - Assert ready at the exit edge and return to IDLE. err holds.
- Write strobe: sram_write_enable is high only in WRITE_S, for exactly one cycle per S element.
- Arithmetic:
  - Operands are two's-complement signed DATA_W.
  - Each product and the running sum are truncated to DATA_W bits (modulo 2^DATA_W), with no saturation.
- Addresses: all address computations wrap modulo 2^ADDR_W.
- Latency:
  - From the accepting edge E0 to ready=1 is N*((D+1)+N*(D+2))+1 cycles.
  - Degenerate or err jobs take 2 cycles.
- Ordering: exactly N*N writes per job, in row-major order of S.
- Read address when idle: sram_read_address holds its last value in IDLE and DONE; the value is don't-care.
- Base addresses: q_base, k_base and s_base are not range-checked. Overlap of the S region with Q/K is the caller's responsibility; behaviour under overlap is undefined.
- Reset timing: reset_n asserted in any state returns to IDLE immediately (asynchronously). No further writes are issued after reset asserts.

Test Plan:
- N=2, D=2, Q=[[1,2],[3,4]] at q_base=0x10, K=[[5,6],[7,8]] at k_base=0x20, s_base=0x30 -> writes 0x30=17, 0x31=23, 0x32=39, 0x33=53 in that order; ready returns 23 cycles after E0; err=0.
- N=1, D=1, Q=[0x00010000], K=[0x00010000] -> single write of 0x00000000 (truncation); Q=[-3], K=[7] -> write 0xFFFFFFEB (-21).
- N=3, D=0 -> no writes; ready high 2 cycles after E0; err=0. Separately, N=2, D=MAX_D+1 -> no reads or writes, err=1; the next valid start clears err.
- Assert reset_n low during the second MAC_K of a 2x2 job -> ready=1 and sram_write_enable=0 immediately; no further writes; a new 2x2 job afterwards produces the correct S.
- Pulse start repeatedly during a busy job with different bases -> all ignored; output matches the latched job only.
- N=4, D=MAX_D with random signed data and s_base=0xFFFE -> 16 writes match a reference model; write addresses wrap 0xFFFE, 0xFFFF, 0x0000, ...
